mux_channel_arbiter: RTL and testbench
======================================

Name: mux_channel_arbiter

Overview:
- Shares one output channel, built as a mux tree, between N_REQ requesters using valid/ready handshakes.
- Round-robin arbitration.
- One registered output stage, so a granted word appears one cycle after acceptance.
- Sits in front of any single-consumer datapath that several producers must drive.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width per requester.
- ID_W, $clog2(N_REQ), width of the granted-requester index.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester valid.
- req_data  input  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot accept to the granted requester; all-zero otherwise.
- out_valid  output  1  output stage holds a word.
- out_data  output  DATA_W  held word.
- out_id  output  ID_W  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_id=0, rr_ptr=0, state=EMPTY.
  - req_ready is combinational and is 0 while rst=1.
  - Reset asserted mid-transfer discards the held word; no partial handshake survives.
- State machine (output stage):
  - EMPTY: out_valid=0. If any req_valid, grant and load the word; go to FULL.
  - FULL, out_ready=1: the word drains this cycle. If any req_valid, grant and load the new word (stay FULL); else go to EMPTY.
  - FULL, out_ready=0: hold out_data and out_id stable; req_ready all-zero.
- can_accept = (state==EMPTY) | out_ready.
- Grant selection:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ..., rr_ptr-1 (wrap modulo N_REQ).
  - req_ready[grant] = can_accept & (|req_valid).
  - Only one requester is accepted per cycle.
- Transfer to requester i occurs when req_valid[i] & req_ready[i].
  - Next edge: out_data <= req_data[i], out_id <= i, out_valid <= 1, rr_ptr <= (i+1) mod N_REQ.
- rr_ptr is unchanged on cycles with no transfer.
- Latency and throughput:
  - Accept at edge t, word visible on out_* after edge t. One-cycle latency.
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Data path: out_data is selected by a binary mux indexed by the grant index. No arithmetic.
- Fairness: with all N_REQ requesters continuously valid and out_ready=1, each is granted exactly once every N_REQ cycles.
- Boundaries:
  - All req_valid low: no grant, rr_ptr held.
  - Single requester valid: granted every accepting cycle, regardless of rr_ptr.
  - rr_ptr wraps from N_REQ-1 to 0.
  - A requester may drop req_valid without a transfer; the arbiter holds no per-requester state.
  - Simultaneous drain and load in FULL: out_valid stays 1 with no bubble.
- out_* must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority. Grant = lowest-index valid requester; rr_ptr is not implemented. All else unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset mid-FULL: load 0xA5 from req 2, assert rst with out_ready=0 -> immediately out_valid=0, out_data=0, out_id=0; after release, first grant searches from 0.
- All four valid, data 0x10/0x11/0x12/0x13, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; out_data matches; out_valid continuous after first load.
- Backpressure: req 1 sends 0x3C, out_ready=0 for 3 cycles -> out_data=0x3C, out_id=1 held; req_ready=0000 throughout; on out_ready=1, next word loads with no bubble.
- Wrap and skip: rr_ptr=3 after a grant to req 2, only req 0 and 2 valid -> req 0 granted, then req 2, then req 0.
- Idle: no req_valid for 5 cycles after one transfer from req 1 -> state EMPTY, out_valid=0, rr_ptr stays 2.
- With MUX_ARB_FIXED_PRIORITY_EN, all valid, out_ready=1 -> out_id=0 every cycle; req_ready=0001 constantly.

Source files
------------

// File: rtl/mux_channel_arbiter.sv
// Valid/ready arbiter sharing one registered output channel between N_REQ requesters.
// Round-robin by default; define MUX_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module mux_channel_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [ID_W-1:0]   out_id_q;
  logic [ID_W-1:0]   grant_d;
  logic              any_valid;
  logic              can_accept;
  logic              xfer;
  logic [DATA_W-1:0] req_words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign req_words[g] = req_data[g*DATA_W +: DATA_W];
  end

`ifdef MUX_ARB_FIXED_PRIORITY_EN
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_d = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) grant_d = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;

  // Walk offsets from the farthest back to the nearest so the closest valid requester wins.
  always_comb begin
    int idx;
    grant_d = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (req_valid[idx]) grant_d = ID_W'(idx);
    end
  end
`endif

  assign any_valid  = |req_valid;
  assign can_accept = (state_q == EMPTY) | out_ready;
  assign xfer       = can_accept & any_valid & ~rst;
  assign req_ready  = xfer ? (N_REQ'(1) << grant_d) : '0;
  assign out_data_d = req_words[grant_d];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      if (xfer) begin
        out_data_q <= out_data_d;
        out_id_q   <= grant_d;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
        rr_ptr_q   <= (grant_d == ID_W'(N_REQ-1)) ? '0 : grant_d + ID_W'(1);
`endif
      end
      case (state_q)
        EMPTY:   if (xfer) state_q <= FULL;
        FULL:    if (out_ready && !xfer) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Directed bench for mux_channel_arbiter: an abstract grant/output model checked every
// cycle, plus hand-computed expectations for reset, rotation, backpressure, wrap and idle.
module tb_mux_channel_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_channel_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the holding register's contents and the requester that currently has first claim.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_id    = 0;
  int           m_ptr   = 0;

  // Winner is the valid requester at the smallest circular distance from the pointer.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best   = -1;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
`ifdef MUX_ARB_FIXED_PRIORITY_EN
        d = i;
`else
        d = (i - ptr + N) % N;
`endif
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g = pick(req_valid, m_ptr);
    if (rst || g < 0 || (m_valid && !out_ready)) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 0;
      m_ptr   <= 0;
    end else if (exp_ready() != '0) begin
      m_valid <= 1'b1;
      m_data  <= req_data[pick(req_valid, m_ptr)*W +: W];
      m_id    <= pick(req_valid, m_ptr);
      m_ptr   <= (pick(req_valid, m_ptr) + 1) % N;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, exp_ready());
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_id", out_id, m_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r);
    req_valid = v;
    out_ready = r;
  endtask

`ifdef MUX_ARB_FIXED_PRIORITY_EN
  int wrap_ids [3] = '{0, 0, 0};
  int sust_ids [4] = '{0, 0, 0, 0};
  logic [N-1:0] idle_ready = 4'b0001;
  int idle_id = 0;
`else
  int wrap_ids [3] = '{0, 2, 0};
  int sust_ids [4] = '{3, 0, 1, 2};
  logic [N-1:0] idle_ready = 4'b0100;
  int idle_id = 2;
`endif

  initial begin
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    drive(4'b1111, 1'b1);
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    rst = 1'b0;
    #1;
    check("first_grant", req_ready, 4'b0001);

    // All four valid: rotation 0,1,2,3,0,1,2,3 with no bubbles.
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_valid", out_valid, 1);
`ifdef MUX_ARB_FIXED_PRIORITY_EN
      check("fp_id", out_id, 0);
      check("fp_data", out_data, 8'h10);
      check("fp_ready", req_ready, 4'b0001);
`else
      check("rr_id", out_id, k % 4);
      check("rr_data", out_data, 8'h10 + k % 4);
`endif
    end

    // Backpressure: word from req 1 held for three cycles, then next word with no bubble.
    req_data[1*W +: W] = 8'h3C;
    drive(4'b0010, 1'b1);
    tick();
    drive(4'b0011, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_ready", req_ready, 4'b0000);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'h3C);
      check("bp_id", out_id, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0001);
    tick();
    check("bp_nobubble_valid", out_valid, 1);
    check("bp_nobubble_id", out_id, 0);
    check("bp_nobubble_data", out_data, 8'h10);

    // Wrap and skip: after a grant to req 2, only reqs 0 and 2 compete.
    drive(4'b0100, 1'b1);
    tick();
    check("wrap_seed_id", out_id, 2);
    drive(4'b0101, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_id", out_id, wrap_ids[k]);
      check("wrap_data", out_data, 8'h10 + wrap_ids[k]);
    end

    // Idle after one transfer from req 1: channel empties, pointer parked at 2.
    drive(4'b0010, 1'b1);
    tick();
    check("idle_seed_data", out_data, 8'h3C);
    drive(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_ready", req_ready, 4'b0000);
    end
    drive(4'b1111, 1'b1);
    #1;
    check("idle_resume_ready", req_ready, idle_ready);
    tick();
    check("idle_resume_id", out_id, idle_id);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sustain_id", out_id, sust_ids[k]);
      check("sustain_valid", out_valid, 1);
    end

    // Reset while FULL and stalled discards the held word.
    req_data[2*W +: W] = 8'hA5;
    drive(4'b0100, 1'b1);
    tick();
    check("mid_load_data", out_data, 8'hA5);
    drive(4'b0000, 1'b0);
    tick();
    check("mid_hold_data", out_data, 8'hA5);
    check("mid_hold_id", out_id, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_id", out_id, 0);
    drive(4'b1111, 1'b1);
    #1;
    check("mid_rst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    tick();
    check("post_rst_id", out_id, 0);
    check("post_rst_data", out_data, 8'h10);

    drive(4'b0000, 1'b1);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
